// File: rtl/rippleadder_n.sv
// rippleadder_n: multi-cycle ripple-carry adder/subtractor.
// Processes one SLICE-bit chunk per clock, LSB first, through a registered carry.
// Uses valid/ready handshakes on input and output and reports carry, zero and negative flags.
// Optional macro RIPPLEADDER_N_OVERFLOW_EN adds the tx_overflowflag output (signed overflow).
module rippleadder_n #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 2
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             rx_enable,
    input  logic             rx_valid,
    output logic             rx_ready,
    input  logic             rx_op,
    input  logic             rx_carryflag,
    input  logic [WIDTH-1:0] rx_addend0,
    input  logic [WIDTH-1:0] rx_addend1,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [WIDTH-1:0] tx_sum,
    output logic             tx_carryflag,
    output logic             tx_zeroflag,
`ifdef RIPPLEADDER_N_OVERFLOW_EN
    output logic             tx_overflowflag,
`endif
    output logic             tx_negflag
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_nxt;
    logic               en_q;
    logic [CNT_W-1:0]   slice_cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   res_q;
    logic               carry_q;
    logic               zacc_q;

    logic               accept;
    logic               finish;
    logic               retire;
    logic [SLICE:0]     sl_sum;
    logic [SLICE-1:0]   sl_s;
    logic               sl_c;
    logic               sl_zero;
    logic [WIDTH-1:0]   res_nxt;
    logic               msb_cin;

    // Single slice add plus the result register with the new slice shifted in from the top
    always_comb begin
        sl_sum  = (SLICE + 1)'(a_q[SLICE-1:0]) + (SLICE + 1)'(b_q[SLICE-1:0])
                + (SLICE + 1)'(carry_q);
        sl_s    = sl_sum[SLICE-1:0];
        sl_c    = sl_sum[SLICE];
        sl_zero = (sl_s == '0);
        res_nxt = (res_q >> SLICE) | (WIDTH'(sl_s) << (WIDTH - SLICE));
        // Carry into the MSB recovered from the MSB's own sum bit
        msb_cin = a_q[SLICE-1] ^ b_q[SLICE-1] ^ sl_s[SLICE-1];
    end

    // Next-state logic and handshake decode
    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        finish    = 1'b0;
        retire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_q && rx_valid && rx_ready) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (en_q && (slice_cnt_q == LAST_SLICE)) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (en_q && tx_valid && tx_ready) begin
                    retire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and registered enable
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            en_q    <= rx_enable;
        end
    end

    // Operand capture and per-slice datapath
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            zacc_q      <= 1'b0;
            slice_cnt_q <= '0;
        end else if (accept) begin
            a_q         <= rx_addend0;
            b_q         <= rx_op ? ~rx_addend1 : rx_addend1;
            res_q       <= '0;
            carry_q     <= rx_carryflag;
            zacc_q      <= 1'b1;
            slice_cnt_q <= '0;
        end else if (en_q && (state_q == RUN)) begin
            a_q     <= a_q >> SLICE;
            b_q     <= b_q >> SLICE;
            res_q   <= res_nxt;
            carry_q <= sl_c;
            zacc_q  <= zacc_q & sl_zero;
            if (!finish) begin
                slice_cnt_q <= slice_cnt_q + CNT_W'(1);
            end
        end
    end

    // Registered handshake outputs; rx_ready tracks IDLE qualified by the registered enable
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rx_ready <= 1'b0;
            tx_valid <= 1'b0;
        end else begin
            rx_ready <= (state_nxt == IDLE) && rx_enable;
            if (finish) begin
                tx_valid <= 1'b1;
            end else if (retire) begin
                tx_valid <= 1'b0;
            end
        end
    end

    // Result and flags load on completion and hold until the next one
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tx_sum       <= '0;
            tx_carryflag <= 1'b0;
            tx_zeroflag  <= 1'b0;
            tx_negflag   <= 1'b0;
        end else if (finish) begin
            tx_sum       <= res_nxt;
            tx_carryflag <= sl_c;
            tx_zeroflag  <= zacc_q & sl_zero;
            tx_negflag   <= res_nxt[WIDTH-1];
        end
    end

`ifdef RIPPLEADDER_N_OVERFLOW_EN
    // Signed overflow: carry into MSB differs from carry out of MSB
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tx_overflowflag <= 1'b0;
        end else if (finish) begin
            tx_overflowflag <= msb_cin ^ sl_c;
        end
    end
`else
    logic unused_msb_cin;
    assign unused_msb_cin = msb_cin;
`endif

endmodule

// File: tb/tb_rippleadder_n.sv
// tb_rippleadder_n: randomized and directed checks of rippleadder_n against an arithmetic model.
module tb_rippleadder_n;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned SLICE  = 2;
    localparam int unsigned NSLICE = WIDTH / SLICE;

    logic             aclk;
    logic             aresetn;
    logic             rx_enable;
    logic             rx_valid;
    logic             rx_ready;
    logic             rx_op;
    logic             rx_carryflag;
    logic [WIDTH-1:0] rx_addend0;
    logic [WIDTH-1:0] rx_addend1;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] tx_sum;
    logic             tx_carryflag;
    logic             tx_zeroflag;
    logic             tx_negflag;
`ifdef RIPPLEADDER_N_OVERFLOW_EN
    logic             tx_overflowflag;
`endif

    int errors = 0;
    int checks = 0;

    rippleadder_n #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .rx_enable       (rx_enable),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .rx_op           (rx_op),
        .rx_carryflag    (rx_carryflag),
        .rx_addend0      (rx_addend0),
        .rx_addend1      (rx_addend1),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .tx_sum          (tx_sum),
        .tx_carryflag    (tx_carryflag),
        .tx_zeroflag     (tx_zeroflag),
`ifdef RIPPLEADDER_N_OVERFLOW_EN
        .tx_overflowflag (tx_overflowflag),
`endif
        .tx_negflag      (tx_negflag)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Compare one observed value with its expected value
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_sum"}, 32'(tx_sum), 32'h0);
        check({tag, "_flags"}, 32'({tx_valid, tx_carryflag, tx_zeroflag, tx_negflag}), 32'h0);
        check({tag, "_rdy"}, 32'(rx_ready), 32'h0);
`ifdef RIPPLEADDER_N_OVERFLOW_EN
        check({tag, "_ovf"}, 32'(tx_overflowflag), 32'h0);
`endif
    endtask

    // Issue one operation, optionally stall enable and apply output backpressure
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic op, input logic cin,
                          input int stall_at, input int stall_len, input int hold);
        logic [WIDTH-1:0] bm;
        logic [WIDTH:0]   full;
        logic             exp_ovf;
        logic [WIDTH-1:0] sum_seen;
        int               lat;

        bm      = op ? ~b : b;
        full    = {1'b0, a} + {1'b0, bm} + (WIDTH + 1)'(cin);
        exp_ovf = (a[WIDTH-1] == bm[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);

        check("rdy_idle", 32'(rx_ready), 32'h1);
        rx_valid     = 1'b1;
        rx_addend0   = a;
        rx_addend1   = b;
        rx_op        = op;
        rx_carryflag = cin;
        tick();
        check("rdy_run", 32'(rx_ready), 32'h0);

        lat = 1;
        while (!tx_valid && lat <= 40) begin
            rx_valid     = 1'($urandom);
            rx_addend0   = WIDTH'($urandom);
            rx_addend1   = WIDTH'($urandom);
            rx_op        = 1'($urandom);
            rx_carryflag = 1'($urandom);
            if (stall_len > 0 && lat == stall_at) rx_enable = 1'b0;
            if (stall_len > 0 && lat == stall_at + stall_len) rx_enable = 1'b1;
            tick();
            if (!tx_valid) lat++;
        end
        rx_enable = 1'b1;
        check("latency", 32'(lat), 32'(NSLICE + stall_len));
        check("sum", 32'(tx_sum), 32'(full[WIDTH-1:0]));
        check("carry", 32'(tx_carryflag), 32'(full[WIDTH]));
        check("zero", 32'(tx_zeroflag), 32'(full[WIDTH-1:0] == '0));
        check("neg", 32'(tx_negflag), 32'(full[WIDTH-1]));
`ifdef RIPPLEADDER_N_OVERFLOW_EN
        check("ovf", 32'(tx_overflowflag), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("unexpected X in overflow model");
`endif

        sum_seen = tx_sum;
        rx_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", 32'(tx_valid), 32'h1);
            check("hold_sum", 32'(tx_sum), 32'(sum_seen));
            check("hold_rdy", 32'(rx_ready), 32'h0);
        end

        rx_valid = 1'b0;
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("retire_valid", 32'(tx_valid), 32'h0);
        check("retire_rdy", 32'(rx_ready), 32'h1);
        check("retire_sum", 32'(tx_sum), 32'(sum_seen));
    endtask

    initial begin
        aresetn      = 1'b0;
        rx_enable    = 1'b1;
        rx_valid     = 1'b0;
        rx_op        = 1'b0;
        rx_carryflag = 1'b0;
        rx_addend0   = '0;
        rx_addend1   = '0;
        tx_ready     = 1'b0;

        repeat (3) tick();
        check_outputs_zero("reset");
        aresetn = 1'b1;
        tick();
        check("rdy_after_reset", 32'(rx_ready), 32'h1);

        run_op(16'h1234, 16'h0001, 1'b0, 1'b0, 0, 0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 0, 0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 0, 0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 0, 0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 0, 5);
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 3, 3, 0);
        run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 0, 0, 1);

        // Reset mid-RUN aborts the operation
        rx_valid   = 1'b1;
        rx_addend0 = 16'h1111;
        rx_addend1 = 16'h2222;
        rx_op      = 1'b0;
        tick();
        rx_valid = 1'b0;
        repeat (4) tick();
        aresetn = 1'b0;
        #1;
        check_outputs_zero("abort");
        tick();
        aresetn = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 15; i++) begin
                tick();
                if (tx_valid) seen++;
            end
            check("abort_no_valid", 32'(seen), 32'h0);
        end
        check("abort_rdy", 32'(rx_ready), 32'h1);
        run_op(16'h4321, 16'h1234, 1'b1, 1'b1, 0, 0, 0);

        for (int n = 0; n < 25; n++) begin
            int sl;
            sl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(1, 4)), sl, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rippleadder_n.md
Name: rippleadder_n

Overview:
Parametrised, multi-cycle ripple-carry adder/subtractor. Successor to the fixed 8-bit strobed adder.
Processes one SLICE-bit chunk per clock, LSB first, through a registered carry, so the carry chain between flops stays short.
Uses valid/ready handshakes on input and output, adds a subtract mode, and reports carry, zero and negative flags.
Sits between the register file and the ALU result mux in the datapath.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of SLICE.
SLICE, 2, bits computed per clock; NSLICE = WIDTH/SLICE; SLICE >= 1.

Ports:
aclk  in  1  clock; all state changes on the rising edge
aresetn  in  1  reset, asynchronous, active-low
rx_enable  in  1  global enable; low freezes all state, forces rx_ready low, holds tx_* stable
rx_valid  in  1  operands and op valid
rx_ready  out  1  block can accept an operation
rx_op  in  1  0 = add, 1 = subtract
rx_carryflag  in  1  carry-in (subtract: 1 = no borrow)
rx_addend0  in  WIDTH  operand A
rx_addend1  in  WIDTH  operand B
tx_valid  out  1  result valid
tx_ready  in  1  consumer accepts result
tx_sum  out  WIDTH  result
tx_carryflag  out  1  carry out of MSB
tx_zeroflag  out  1  tx_sum == 0
tx_negflag  out  1  tx_sum[WIDTH-1]

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; slice counter = 0.
  - tx_sum, tx_carryflag, tx_zeroflag, tx_negflag, tx_valid all 0; operand and carry registers 0.
  - rx_ready = 1 once rx_enable is sampled high.
- rx_enable is registered once before use, so it takes effect one cycle late. All transitions below require the registered enable.
- Arithmetic:
  - add: A + B + cin.
  - sub: A + ~B + cin. B is inverted at capture. With cin = 1 this gives A - B; carry out = 1 means no borrow.
- IDLE:
  - rx_ready = 1.
  - Handshake rx_valid & rx_ready at an edge captures A, B (inverted if sub) and cin into the carry register, clears the slice counter, and moves to RUN.
- RUN:
  - Each enabled edge computes {c, s} = A[k*SLICE +: SLICE] + B[k*SLICE +: SLICE] + carry.
  - s is written into the result register at slice k; carry <= c; k <= k + 1.
  - At the edge processing k = NSLICE-1, move to DONE. tx_sum and the flags are loaded from the completed result and tx_valid is set.
  - rx_ready = 0 throughout.
- DONE:
  - tx_valid = 1; tx_* stay stable.
  - tx_valid & tx_ready at an edge clears tx_valid and moves to IDLE. No input is accepted in the same cycle (no bypass).
  - tx_sum and the flags keep their last value until the next completion.
- Latency: tx_valid is high NSLICE cycles after the input-handshake edge (8 at the defaults). Throughput is one operation per NSLICE + 2 cycles.
- tx_zeroflag is the AND of the per-slice zero indications over the final result.
- rx_valid outside IDLE is ignored; it is not queued.
- Operand inputs may change freely after capture; the result depends only on captured values.
- Slice counter width is clog2(NSLICE), minimum 1. It never wraps: it leaves RUN at NSLICE-1.
- aresetn low mid-RUN or mid-DONE aborts the operation: no tx_valid, all outputs return to reset values.
- rx_enable low mid-RUN stalls the counter and carry. Latency extends by the stalled cycles; the result is unchanged.

Optional Feature:
RIPPLEADDER_N_OVERFLOW_EN:
- Defined: adds output tx_overflowflag (1 bit, reset 0), the signed overflow of the full operation.
  - Computed as (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
  - Loaded with the other flags on entry to DONE.
- Undefined: the port and its logic are absent; everything else is identical.

Test Plan:
- Defaults; add A=0x1234, B=0x0001, cin=0 -> tx_sum 0x1235, C0 Z0 N0; tx_valid exactly 8 cycles after the accept edge.
- Add A=0xFFFF, B=0x0001, cin=0 -> tx_sum 0x0000, C1 Z1 N0; overflow 0 with RIPPLEADDER_N_OVERFLOW_EN.
- Sub A=0x0005, B=0x0007, cin=1 -> tx_sum 0xFFFE, C0 Z0 N1. Sub A=0x8000, B=0x0001, cin=1 -> tx_sum 0x7FFF, C1 N0, overflow 1.
- Backpressure: hold tx_ready low 5 cycles after tx_valid with rx_valid high -> tx_* stable, rx_ready 0, no capture. Raise tx_ready -> IDLE next cycle, new operation accepted the cycle after.
- Deassert rx_enable for 3 cycles mid-RUN during 0x00FF+0x0001 -> tx_valid at 11 cycles, tx_sum 0x0100.
- Pulse aresetn low at RUN slice 4 -> all outputs 0, tx_valid never rises. After release, with enable, rx_ready = 1 and the next operation completes correctly.
